// File: rtl/wm_phase_timer.sv
// wm_phase_timer: phase duration counting, fill/heat watchdogs, water-level
// debounce and temperature compare feeding the washing-machine controller.
// Optional build macro: WM_PHASE_TIMER_LID_PAUSE_EN freezes WASH/RINSE/SPIN
// timing while sig_Lid_Closed is low.
module wm_phase_timer #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FILL_TIMEOUT = 120,
    parameter int unsigned HEAT_TIMEOUT = 300,
    parameter int unsigned WASH_TICKS   = 600,
    parameter int unsigned RINSE_TICKS  = 300,
    parameter int unsigned SPIN_TICKS   = 180,
    parameter int unsigned TEMP_TARGET  = 40,
    parameter int unsigned DB_LEN       = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       state,
    input  logic             level_Raw,
    input  logic [7:0]       temp_Value,
    input  logic             sig_Lid_Closed,
    output logic             sig_Full,
    output logic             sig_Temperature,
    output logic             sig_Time_Out,
    output logic             sig_Completed,
    output logic             water_Valve,
    output logic             heater_On,
    output logic [CNT_W-1:0] phase_Remaining
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W  = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;

    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_HEAT  = 3'd3;
    localparam logic [2:0] ST_WASH  = 3'd4;
    localparam logic [2:0] ST_RINSE = 3'd5;
    localparam logic [2:0] ST_SPIN  = 3'd6;

    logic [2:0]       state_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_c, rem_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic             full_d;
    logic             done_d, tout_d;
    logic             entry_c, tick_c;
    logic             timed_c, watch_c, suppress_c, freeze_c;

    assign entry_c = (state != state_q);
    assign tick_c  = (presc_q == PRE_W'(TICK_DIV - 1));

    // Per-phase limit and classification (timed phase vs. watchdog phase)
    always_comb begin
        limit_c    = '0;
        timed_c    = 1'b0;
        watch_c    = 1'b0;
        suppress_c = 1'b0;
        case (state)
            ST_FILL: begin
                limit_c    = CNT_W'(FILL_TIMEOUT);
                timed_c    = 1'b1;
                watch_c    = 1'b1;
                suppress_c = sig_Full;
            end
            ST_HEAT: begin
                limit_c    = CNT_W'(HEAT_TIMEOUT);
                timed_c    = 1'b1;
                watch_c    = 1'b1;
                suppress_c = sig_Temperature;
            end
            ST_WASH: begin
                limit_c = CNT_W'(WASH_TICKS);
                timed_c = 1'b1;
            end
            ST_RINSE: begin
                limit_c = CNT_W'(RINSE_TICKS);
                timed_c = 1'b1;
            end
            ST_SPIN: begin
                limit_c = CNT_W'(SPIN_TICKS);
                timed_c = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef WM_PHASE_TIMER_LID_PAUSE_EN
    assign freeze_c = timed_c && !watch_c && !sig_Lid_Closed;
`else
    logic unused_lid;
    assign unused_lid = sig_Lid_Closed;
    assign freeze_c   = 1'b0;
`endif

    // Next prescaler/counter values and pulse qualification
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        if (entry_c) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (!freeze_c) begin
            presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
            if (!timed_c) begin
                cnt_d = '0;
            end else if (tick_c && (cnt_q < limit_c)) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == limit_c - CNT_W'(1)) begin
                    done_d = !watch_c;
                    tout_d = watch_c && !suppress_c;
                end
            end
        end
        rem_d = timed_c ? (limit_c - cnt_d) : '0;
    end

    // Level debounce: toggle after DB_LEN consecutive disagreeing cycles
    always_comb begin
        db_d   = '0;
        full_d = sig_Full;
        if (level_Raw != sig_Full) begin
            if (db_q == DB_W'(DB_LEN - 1)) begin
                full_d = ~sig_Full;
            end else begin
                db_d = db_q + DB_W'(1);
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= '0;
            presc_q         <= '0;
            cnt_q           <= '0;
            db_q            <= '0;
            sig_Full        <= 1'b0;
            sig_Temperature <= 1'b0;
            sig_Time_Out    <= 1'b0;
            sig_Completed   <= 1'b0;
            phase_Remaining <= '0;
        end else begin
            state_q         <= state;
            presc_q         <= presc_d;
            cnt_q           <= cnt_d;
            db_q            <= db_d;
            sig_Full        <= full_d;
            sig_Temperature <= (32'(temp_Value) >= TEMP_TARGET);
            sig_Time_Out    <= tout_d;
            sig_Completed   <= done_d;
            phase_Remaining <= rem_d;
        end
    end

    // Actuator requests straight from the phase code and registered sensors
    assign water_Valve = (state == ST_FILL) && !sig_Full;
    assign heater_On   = (state == ST_HEAT) && !sig_Temperature;

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Timing and sensor-conditioning stage directly upstream of the washing-machine controller FSM.
- Observes the controller's 3-bit state code and produces the controller's inputs `sig_Full`, `sig_Temperature`, `sig_Time_Out` and `sig_Completed`.
- Provides per-phase duration counting (wash/rinse/spin), fill/heat watchdogs, water-level debouncing and a temperature threshold compare, so the controller itself stays purely combinational next-state logic.

Parameters:
- TICK_DIV, 50000: clock cycles per timer tick; must be ≥ 1.
- CNT_W, 16: width of the phase counter and of `phase_Remaining`.
- FILL_TIMEOUT, 120: ticks allowed in FILL_WATER before a timeout.
- HEAT_TIMEOUT, 300: ticks allowed in HEAT_WATER before a timeout.
- WASH_TICKS, 600: WASH duration in ticks.
- RINSE_TICKS, 300: RINSE duration in ticks.
- SPIN_TICKS, 180: SPIN duration in ticks.
- TEMP_TARGET, 40: `temp_Value` threshold (unsigned).
- DB_LEN, 4: consecutive stable cycles required on `level_Raw`.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- state  in  3  controller state code: 0 START, 1 READY, 2 FILL_WATER, 3 HEAT_WATER, 4 WASH, 5 RINSE, 6 SPIN, 7 FAULT
- level_Raw  in  1  raw water-full float switch (may bounce)
- temp_Value  in  8  unsigned temperature sample
- sig_Lid_Closed  in  1  lid switch (used only with LID_PAUSE_EN)
- sig_Full  out  1  debounced water-full level
- sig_Temperature  out  1  registered (`temp_Value` >= TEMP_TARGET)
- sig_Time_Out  out  1  one-cycle watchdog pulse
- sig_Completed  out  1  one-cycle phase-done pulse
- water_Valve  out  1  high in FILL_WATER while `sig_Full` = 0
- heater_On  out  1  high in HEAT_WATER while `sig_Temperature` = 0
- phase_Remaining  out  CNT_W  ticks left in the current timed phase; 0 otherwise

Behaviour:

Reset:
- `reset_n` low asynchronously clears all registers.
- All outputs are 0. `state_q` = 0, the prescaler = 0, the counter = 0, and the debounce counter and `sig_Full` = 0.
- Deassertion takes effect at the next clock edge. Reset mid-phase simply restarts from zero.

Phase-change detection:
- `state_q` registers `state` every cycle.
- A cycle with `state` != `state_q` is a phase entry. On that edge the prescaler and the phase counter clear to 0 and no pulse is issued.
- Re-entering the same phase (e.g. SPIN -> READY -> ... -> SPIN) always restarts from zero.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps. `tick` is a combinational strobe, asserted when prescaler == TICK_DIV-1.
- With TICK_DIV = 1, `tick` is asserted every cycle.
- The prescaler runs in every state.

Phase counter:
- In states 2–6, increments on `tick` and saturates at its limit, LIMIT(state): 2 → FILL_TIMEOUT, 3 → HEAT_TIMEOUT, 4 → WASH_TICKS, 5 → RINSE_TICKS, 6 → SPIN_TICKS.
- In states 0, 1 and 7 it is held at 0.

Output pulses:
- `sig_Completed`: registered one-cycle pulse, issued in states 4–6 on the tick where the counter reaches LIMIT-1.
- `sig_Time_Out`: registered one-cycle pulse, issued in states 2–3 on the tick where the counter reaches LIMIT-1.
- `sig_Time_Out` is suppressed if `sig_Full` (state 2) or `sig_Temperature` (state 3) is 1 in that same cycle.
- Latency from the qualifying tick to the pulse is 1 cycle.
- After saturation no further pulse is issued until the next phase entry. At most one pulse is issued per phase visit.

`phase_Remaining`:
- Registered, = LIMIT - counter in states 2–6; 0 in all other states.

Debounce:
- A counter tracks cycles where `level_Raw` != `sig_Full`.
- `sig_Full` toggles after DB_LEN consecutive differing cycles; any agreeing cycle clears the counter.
- The debounce runs in all states.

`sig_Temperature`:
- Compare registered every cycle, with no hysteresis.

`water_Valve` / `heater_On`:
- Combinational from `state` and the registered `sig_Full` / `sig_Temperature`. Glitch-free because all inputs are registered.

Optional Feature:
- Macro: `WM_PHASE_TIMER_LID_PAUSE_EN`.
- Defined: in states 4–6, while `sig_Lid_Closed` = 0, the prescaler and the phase counter freeze and no pulse is issued. Counting resumes from the held values when the lid closes.
- Undefined: `sig_Lid_Closed` is ignored; the port remains present but is unused.

Test Plan:
1. **Reset:** assert `reset_n` = 0 mid-WASH with the counter at 5 → all outputs 0 immediately. Release with `state` = 4 → `phase_Remaining` counts down from WASH_TICKS again.
2. **Wash completion** (TICK_DIV = 4, WASH_TICKS = 3): set `state` = 4 → `sig_Completed` high for exactly 1 cycle, 12 cycles after entry (3 ticks × 4 cycles), then stays 0 while `state` holds at 4.
3. **Fill timeout** (TICK_DIV = 2, FILL_TIMEOUT = 5): `state` = 2, `level_Raw` = 0 → `water_Valve` = 1 and a single `sig_Time_Out` pulse 10 cycles after entry. Repeat with `level_Raw` = 1 stable from entry (DB_LEN = 4) → `sig_Full` = 1 by cycle 5, `water_Valve` drops, and no `sig_Time_Out`.
4. **Debounce:** `level_Raw` toggled 1,0,1,1,0 over 5 cycles → `sig_Full` stays 0. Then held at 1 for 4 cycles → `sig_Full` = 1 on the following edge.
5. **Temperature and phase change:** `temp_Value` 39 → 40 in `state` = 3 → `sig_Temperature` rises 1 cycle later and `heater_On` falls. Then switch `state` 3 → 4 in mid-tick → counter and prescaler restart and `phase_Remaining` = WASH_TICKS.
6. **Lid pause** (with `WM_PHASE_TIMER_LID_PAUSE_EN`): `state` = 6, `sig_Lid_Closed` = 0 for 20 cycles in mid-phase → `phase_Remaining` constant. Re-close → `sig_Completed` is delayed by exactly 20 cycles versus the unpaused run.
